// File: rtl/traffic_light_fsm.sv
// rtl/traffic_light_fsm.sv - highway/farm-road intersection controller driving long and short phase timers
module traffic_light_fsm #(
    parameter int SYNC_STAGES = 2,
    parameter bit ALLRED_EN   = 1'b1
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       car,
    input  logic       ts_done,
    input  logic       tl_done,
    output logic       ts_start,
    output logic       tl_start,
    output logic [1:0] hwy_light,
    output logic [1:0] farm_light,
    output logic [2:0] state_o
);

    localparam logic [2:0] HG  = 3'd0;
    localparam logic [2:0] HY  = 3'd1;
    localparam logic [2:0] ARH = 3'd2;
    localparam logic [2:0] FG  = 3'd3;
    localparam logic [2:0] FY  = 3'd4;
    localparam logic [2:0] ARF = 3'd5;

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] GREEN  = 2'b10;

    logic [2:0]             state;
    logic [2:0]             next_state;
    logic                   entry;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   car_s;

    assign car_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state  <= HG;
            entry  <= 1'b1;
            sync_q <= '0;
        end else begin
            state  <= next_state;
            entry  <= (next_state != state);
            sync_q[0] <= car;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Timer expiries are masked in the entry cycle: the timer still holds a stale count from its last run.
    always_comb begin
        next_state = state;
        if (state > ARF) begin
            next_state = HG;
        end else if (!entry) begin
            case (state)
                HG:      if (tl_done && car_s) next_state = HY;
                HY:      if (ts_done) next_state = ALLRED_EN ? ARH : FG;
                ARH:     if (ts_done) next_state = FG;
                FG:      if (tl_done || !car_s) next_state = FY;
                FY:      if (ts_done) next_state = ALLRED_EN ? ARF : HG;
                ARF:     if (ts_done) next_state = HG;
                default: next_state = HG;
            endcase
        end
    end

    always_comb begin
        hwy_light  = RED;
        farm_light = RED;
        tl_start   = 1'b0;
        ts_start   = 1'b0;
        case (state)
            HG: begin
                hwy_light = GREEN;
                tl_start  = entry;
            end
            HY: begin
                hwy_light = YELLOW;
                ts_start  = entry;
            end
            ARH: ts_start = entry;
            FG: begin
                farm_light = GREEN;
                tl_start   = entry;
            end
            FY: begin
                farm_light = YELLOW;
                ts_start   = entry;
            end
            ARF: ts_start = entry;
            default: ;
        endcase
    end

    assign state_o = state;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// tb/tb_traffic_light_fsm.sv - directed self-checking bench for traffic_light_fsm
module tb_traffic_light_fsm;

    logic       clk = 1'b0;
    logic       arst = 1'b0;
    logic       car = 1'b0;
    logic       force_ts = 1'b0;
    logic       force_tl = 1'b0;

    logic       ts_start_a, tl_start_a, ts_start_b, tl_start_b;
    logic [1:0] hwy_a, farm_a, hwy_b, farm_b;
    logic [2:0] st_a, st_b;
    logic [2:0] ts_cnt_a = 3'd0, tl_cnt_a = 3'd0, ts_cnt_b = 3'd0, tl_cnt_b = 3'd0;
    logic       ts_done_a, tl_done_a, ts_done_b, tl_done_b;

    int tests = 0;
    int fails = 0;

    // Lamp codes indexed by state code
    logic [1:0] exp_hwy  [0:5] = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [1:0] exp_farm [0:5] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00};

    traffic_light_fsm #(.SYNC_STAGES(2), .ALLRED_EN(1'b1)) dut_a (
        .clk(clk), .arst(arst), .car(car),
        .ts_done(ts_done_a), .tl_done(tl_done_a),
        .ts_start(ts_start_a), .tl_start(tl_start_a),
        .hwy_light(hwy_a), .farm_light(farm_a), .state_o(st_a)
    );

    traffic_light_fsm #(.SYNC_STAGES(2), .ALLRED_EN(1'b0)) dut_b (
        .clk(clk), .arst(arst), .car(car),
        .ts_done(ts_done_b), .tl_done(tl_done_b),
        .ts_start(ts_start_b), .tl_start(tl_start_b),
        .hwy_light(hwy_b), .farm_light(farm_b), .state_o(st_b)
    );

    always #5 clk = ~clk;

    // 3-bit count-up timers: clear while start is high, done at count 7
    always @(posedge clk) begin
        ts_cnt_a <= ts_start_a ? 3'd0 : ts_cnt_a + 3'd1;
        tl_cnt_a <= tl_start_a ? 3'd0 : tl_cnt_a + 3'd1;
        ts_cnt_b <= ts_start_b ? 3'd0 : ts_cnt_b + 3'd1;
        tl_cnt_b <= tl_start_b ? 3'd0 : tl_cnt_b + 3'd1;
    end

    assign ts_done_a = force_ts | (ts_cnt_a == 3'd7);
    assign tl_done_a = force_tl | (tl_cnt_a == 3'd7);
    assign ts_done_b = force_ts | (ts_cnt_b == 3'd7);
    assign tl_done_b = force_tl | (tl_cnt_b == 3'd7);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("safe_a", 32'((hwy_a == 2'b00) || (farm_a == 2'b00)), 32'd1);
        chk("safe_b", 32'((hwy_b == 2'b00) || (farm_b == 2'b00)), 32'd1);
    endtask

    task automatic do_reset();
        arst = 1'b1;
        tick();
        arst = 1'b0;
    endtask

    task automatic phase_a(input logic [2:0] st, input int len);
        bit green;
        green = (st == 3'd0) || (st == 3'd3);
        for (int c = 0; c < len; c++) begin
            chk("a_state", 32'(st_a), 32'(st));
            chk("a_hwy", 32'(hwy_a), 32'(exp_hwy[st]));
            chk("a_farm", 32'(farm_a), 32'(exp_farm[st]));
            chk("a_tl_start", 32'(tl_start_a), 32'((c == 0) && green));
            chk("a_ts_start", 32'(ts_start_a), 32'((c == 0) && !green));
            tick();
        end
    endtask

    task automatic phase_b(input logic [2:0] st, input int len);
        bit green;
        green = (st == 3'd0) || (st == 3'd3);
        for (int c = 0; c < len; c++) begin
            chk("b_state", 32'(st_b), 32'(st));
            chk("b_no_allred", 32'((st_b != 3'd2) && (st_b != 3'd5)), 32'd1);
            chk("b_tl_start", 32'(tl_start_b), 32'((c == 0) && green));
            chk("b_ts_start", 32'(ts_start_b), 32'((c == 0) && !green));
            tick();
        end
    endtask

    initial begin
        logic [2:0] fast_seq [0:5];
        fast_seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};

        // Asynchronous reset takes effect before any clock edge
        #2 arst = 1'b1;
        #1;
        chk("rst_state", 32'(st_a), 32'd0);
        chk("rst_hwy", 32'(hwy_a), 32'd2);
        chk("rst_farm", 32'(farm_a), 32'd0);
        chk("rst_tl_start", 32'(tl_start_a), 32'd1);
        chk("rst_ts_start", 32'(ts_start_a), 32'd0);
        tick();
        tick();
        arst = 1'b0;
        chk("rel_state", 32'(st_a), 32'd0);
        chk("rel_tl_start", 32'(tl_start_a), 32'd1);

        // No car: HG holds through repeated long-timer expiries
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("idle_state", 32'(st_a), 32'd0);
            chk("idle_tl_start", 32'(tl_start_a), 32'd0);
            chk("idle_hwy", 32'(hwy_a), 32'd2);
            chk("idle_farm", 32'(farm_a), 32'd0);
        end

        // Full cycle with all-red clearance, 9 cycles per phase
        car = 1'b1;
        do_reset();
        phase_a(3'd0, 9);
        phase_a(3'd1, 9);
        phase_a(3'd2, 9);
        phase_a(3'd3, 9);
        phase_a(3'd4, 9);
        phase_a(3'd5, 9);
        chk("wrap_state", 32'(st_a), 32'd0);
        chk("wrap_tl_start", 32'(tl_start_a), 32'd1);

        // Car leaves after FG cycle 3: FY begins at FG cycle 3 + 2 + SYNC_STAGES = 7
        do_reset();
        phase_a(3'd0, 9);
        phase_a(3'd1, 9);
        phase_a(3'd2, 9);
        for (int c = 1; c <= 3; c++) begin
            chk("fg_early_state", 32'(st_a), 32'd3);
            tick();
        end
        car = 1'b0;
        for (int c = 4; c <= 6; c++) begin
            chk("fg_hold_state", 32'(st_a), 32'd3);
            tick();
        end
        chk("fy_state", 32'(st_a), 32'd4);
        chk("fy_ts_start", 32'(ts_start_a), 32'd1);
        chk("fy_tl_start", 32'(tl_start_a), 32'd0);
        chk("fy_farm", 32'(farm_a), 32'd1);

        // Reset mid-FY, then a stale done must not move HG out of its entry cycle
        tick();
        arst = 1'b1;
        #1;
        chk("mid_rst_async", 32'(st_a), 32'd0);
        tick();
        arst = 1'b0;
        force_ts = 1'b1;
        force_tl = 1'b1;
        chk("post_rst_state", 32'(st_a), 32'd0);
        chk("post_rst_hwy", 32'(hwy_a), 32'd2);
        chk("post_rst_tl_start", 32'(tl_start_a), 32'd1);
        chk("post_rst_ts_start", 32'(ts_start_a), 32'd0);
        tick();
        chk("stale_done_state", 32'(st_a), 32'd0);
        chk("stale_done_tl_start", 32'(tl_start_a), 32'd0);
        force_ts = 1'b0;
        force_tl = 1'b0;

        // Both done inputs stuck high: each state lasts entry cycle plus one
        car = 1'b1;
        do_reset();
        tick();
        tick();
        force_ts = 1'b1;
        force_tl = 1'b1;
        tick();
        for (int p = 0; p < 6; p++) begin
            phase_a(fast_seq[p], 2);
        end
        chk("fast_wrap_state", 32'(st_a), 32'd1);
        force_ts = 1'b0;
        force_tl = 1'b0;

        // All-red disabled
        car = 1'b1;
        do_reset();
        phase_b(3'd0, 9);
        phase_b(3'd1, 9);
        phase_b(3'd3, 9);
        phase_b(3'd4, 9);
        chk("b_wrap_state", 32'(st_b), 32'd0);
        chk("b_wrap_tl_start", 32'(tl_start_b), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
